// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - D-stage class/register inputs, flush, stall and forward-select bundle
interface hazard_ctrl_if;
  logic       d_b;
  logic       d_cal_r;
  logic       d_cal_i;
  logic       d_load;
  logic       d_store;
  logic       d_jr;
  logic       d_jalr;
  logic       d_jal;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [4:0] d_rd;
  logic       flush;
  logic       stall;
  logic [1:0] fwd_d_rs;
  logic [1:0] fwd_d_rt;
  logic [1:0] fwd_e_rs;
  logic [1:0] fwd_e_rt;
  logic       fwd_m_rt;

  modport master (
    output d_b, d_cal_r, d_cal_i, d_load, d_store, d_jr, d_jalr, d_jal,
    output d_rs, d_rt, d_rd, flush,
    input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt
  );

  modport slave (
    input  d_b, d_cal_r, d_cal_i, d_load, d_store, d_jr, d_jalr, d_jal,
    input  d_rs, d_rt, d_rd, flush,
    output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - E/M/W scoreboard driving D-stage stall and forwarding-mux selects
// HAZ_FWD_EN enables forwarding; without it every live dependency stalls until the writer retires.
module hazard_ctrl (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave hif
);
  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rs_used;
    logic       rt_used;
  } entry_t;

  entry_t d_ent;
  entry_t e_q, m_q, w_q;
  entry_t e_d, m_d, w_d;

  function automatic logic hit(input logic used, input logic [4:0] src, input entry_t ent);
    return used && (src != 5'd0) && ent.valid && (ent.dst == src);
  endfunction

  always_comb begin
    d_ent         = '0;
    d_ent.valid   = 1'b1;
    d_ent.rs      = hif.d_rs;
    d_ent.rt      = hif.d_rt;
    d_ent.rs_used = hif.d_b | hif.d_jr | hif.d_jalr | hif.d_cal_r |
                    hif.d_cal_i | hif.d_load | hif.d_store;
    d_ent.rt_used = hif.d_b | hif.d_cal_r | hif.d_store;
    if (hif.d_cal_r) begin
      d_ent.dst  = hif.d_rd;
      d_ent.tnew = 2'd1;
    end else if (hif.d_cal_i) begin
      d_ent.dst  = hif.d_rt;
      d_ent.tnew = 2'd1;
    end else if (hif.d_load) begin
      d_ent.dst  = hif.d_rt;
      d_ent.tnew = 2'd2;
    end else if (hif.d_jalr) begin
      d_ent.dst  = hif.d_rd;
    end else if (hif.d_jal) begin
      d_ent.dst  = 5'd31;
    end
  end

`ifdef HAZ_FWD_EN
  logic [1:0] rs_tuse;
  logic [1:0] rt_tuse;

  function automatic logic ready(input logic used, input logic [4:0] src, input entry_t ent);
    return hit(used, src, ent) && (ent.tnew == 2'd0);
  endfunction

  always_comb begin
    rs_tuse = (hif.d_cal_r | hif.d_cal_i | hif.d_load | hif.d_store) ? 2'd1 : 2'd0;
    rt_tuse = hif.d_store ? 2'd2 : (hif.d_cal_r ? 2'd1 : 2'd0);
  end

  // A source stalls only while its producer cannot deliver before the source is consumed.
  always_comb begin
    hif.stall = (hit(d_ent.rs_used, d_ent.rs, e_q) && (e_q.tnew > rs_tuse)) ||
                (hit(d_ent.rs_used, d_ent.rs, m_q) && (m_q.tnew > rs_tuse)) ||
                (hit(d_ent.rt_used, d_ent.rt, e_q) && (e_q.tnew > rt_tuse)) ||
                (hit(d_ent.rt_used, d_ent.rt, m_q) && (m_q.tnew > rt_tuse));
    hif.fwd_d_rs = ready(d_ent.rs_used, d_ent.rs, e_q) ? 2'd1 :
                   ready(d_ent.rs_used, d_ent.rs, m_q) ? 2'd2 :
                   ready(d_ent.rs_used, d_ent.rs, w_q) ? 2'd3 : 2'd0;
    hif.fwd_d_rt = ready(d_ent.rt_used, d_ent.rt, e_q) ? 2'd1 :
                   ready(d_ent.rt_used, d_ent.rt, m_q) ? 2'd2 :
                   ready(d_ent.rt_used, d_ent.rt, w_q) ? 2'd3 : 2'd0;
    hif.fwd_e_rs = ready(e_q.rs_used, e_q.rs, m_q) ? 2'd2 :
                   ready(e_q.rs_used, e_q.rs, w_q) ? 2'd3 : 2'd0;
    hif.fwd_e_rt = ready(e_q.rt_used, e_q.rt, m_q) ? 2'd2 :
                   ready(e_q.rt_used, e_q.rt, w_q) ? 2'd3 : 2'd0;
    hif.fwd_m_rt = ready(m_q.rt_used, m_q.rt, w_q);
  end
`else
  // No bypass paths and no write-through regfile: wait until the writer has left W.
  always_comb begin
    hif.stall = hit(d_ent.rs_used, d_ent.rs, e_q) || hit(d_ent.rs_used, d_ent.rs, m_q) ||
                hit(d_ent.rs_used, d_ent.rs, w_q) || hit(d_ent.rt_used, d_ent.rt, e_q) ||
                hit(d_ent.rt_used, d_ent.rt, m_q) || hit(d_ent.rt_used, d_ent.rt, w_q);
    hif.fwd_d_rs = 2'd0;
    hif.fwd_d_rt = 2'd0;
    hif.fwd_e_rs = 2'd0;
    hif.fwd_e_rt = 2'd0;
    hif.fwd_m_rt = 1'b0;
  end
`endif

  // flush kills E and M but lets the older M instruction retire into W.
  always_comb begin
    w_d      = m_q;
    w_d.tnew = 2'd0;
    m_d      = e_q;
    m_d.tnew = (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
    e_d      = d_ent;
    if (hif.flush) begin
      m_d = '0;
      e_d = '0;
    end else if (hif.stall) begin
      e_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed and random checks of hazard_ctrl against an instruction-age pipeline model
module tb_hazard_ctrl;
  localparam int C_NONE = 0, C_B = 1, C_CALR = 2, C_CALI = 3, C_LOAD = 4;
  localparam int C_STORE = 5, C_JR = 6, C_JALR = 7, C_JAL = 8;
`ifdef HAZ_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_ctrl_if hif ();
  hazard_ctrl u_dut (.clk(clk), .rst_n(rst_n), .hif(hif));

  int n_vec = 0;
  int n_err = 0;

  int dcls, drs, drt, drd;
  bit pv[3];
  int pcls[3], prs[3], prt[3], prd[3];
  logic obs_stall;
  logic [1:0] obs_fwd_d_rs;
  int cnt;

  function automatic int dst_of(int cls, int rt, int rd);
    case (cls)
      C_CALR, C_JALR: return rd;
      C_CALI, C_LOAD: return rt;
      C_JAL:          return 31;
      default:        return 0;
    endcase
  endfunction

  function automatic int tnew0(int cls);
    case (cls)
      C_CALR, C_CALI: return 1;
      C_LOAD:         return 2;
      default:        return 0;
    endcase
  endfunction

  function automatic int use_rs(int cls);
    case (cls)
      C_B, C_JR, C_JALR:                return 0;
      C_CALR, C_CALI, C_LOAD, C_STORE: return 1;
      default:                          return -1;
    endcase
  endfunction

  function automatic int use_rt(int cls);
    case (cls)
      C_B:     return 0;
      C_CALR:  return 1;
      C_STORE: return 2;
      default: return -1;
    endcase
  endfunction

  // Remaining latency of the instruction k stages past D.
  function automatic int ptnew(int k);
    int t;
    t = tnew0(pcls[k]) - k;
    return (t < 0) ? 0 : t;
  endfunction

  function automatic bit pmatch(int k, int r);
    return pv[k] && (r != 0) && (dst_of(pcls[k], prt[k], prd[k]) == r);
  endfunction

  function automatic bit model_stall();
    int ru, tu;
    ru = use_rs(dcls);
    tu = use_rt(dcls);
    for (int k = 0; k < 3; k++) begin
      if (ru >= 0 && pmatch(k, drs) && (!FWD || (k < 2 && ptnew(k) > ru))) return 1'b1;
      if (tu >= 0 && pmatch(k, drt) && (!FWD || (k < 2 && ptnew(k) > tu))) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int model_fwd(int r, bit used, int kstart);
    int res;
    res = 0;
    if (used && r != 0) begin
      for (int k = 2; k >= kstart; k--)
        if (pmatch(k, r) && ptnew(k) == 0) res = k + 1;
    end
    return FWD ? res : 0;
  endfunction

  task automatic chk(string tag, logic [1:0] obs, logic [1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("stall", hif.stall, model_stall());
    chk("fwd_d_rs", hif.fwd_d_rs, 2'(model_fwd(drs, use_rs(dcls) >= 0, 0)));
    chk("fwd_d_rt", hif.fwd_d_rt, 2'(model_fwd(drt, use_rt(dcls) >= 0, 0)));
    chk("fwd_e_rs", hif.fwd_e_rs, 2'(model_fwd(prs[0], pv[0] && use_rs(pcls[0]) >= 0, 1)));
    chk("fwd_e_rt", hif.fwd_e_rt, 2'(model_fwd(prt[0], pv[0] && use_rt(pcls[0]) >= 0, 1)));
    chk("fwd_m_rt", hif.fwd_m_rt, (model_fwd(prt[1], pv[1] && use_rt(pcls[1]) >= 0, 2) == 3));
  endtask

  task automatic clear_model();
    for (int k = 0; k < 3; k++) begin
      pv[k] = 1'b0; pcls[k] = C_NONE; prs[k] = 0; prt[k] = 0; prd[k] = 0;
    end
  endtask

  task automatic advance(bit s, bit fl);
    if (!rst_n) begin
      clear_model();
    end else begin
      pv[2] = pv[1]; pcls[2] = pcls[1]; prs[2] = prs[1]; prt[2] = prt[1]; prd[2] = prd[1];
      pv[1] = pv[0]; pcls[1] = pcls[0]; prs[1] = prs[0]; prt[1] = prt[0]; prd[1] = prd[0];
      pv[0] = 1'b1; pcls[0] = dcls; prs[0] = drs; prt[0] = drt; prd[0] = drd;
      if (fl) begin
        pv[1] = 1'b0; pcls[1] = C_NONE;
      end
      if (fl || s) begin
        pv[0] = 1'b0; pcls[0] = C_NONE;
      end
    end
  endtask

  task automatic set_d(int cls, int rs, int rt, int rd);
    dcls = cls; drs = rs; drt = rt; drd = rd;
    hif.d_b     = (cls == C_B);
    hif.d_cal_r = (cls == C_CALR);
    hif.d_cal_i = (cls == C_CALI);
    hif.d_load  = (cls == C_LOAD);
    hif.d_store = (cls == C_STORE);
    hif.d_jr    = (cls == C_JR);
    hif.d_jalr  = (cls == C_JALR);
    hif.d_jal   = (cls == C_JAL);
    hif.d_rs    = 5'(rs);
    hif.d_rt    = 5'(rt);
    hif.d_rd    = 5'(rd);
  endtask

  task automatic cycle(int cls, int rs, int rt, int rd, bit fl);
    bit s;
    set_d(cls, rs, rt, rd);
    hif.flush = fl;
    #1;
    s = model_stall();
    check_outputs();
    obs_stall    = hif.stall;
    obs_fwd_d_rs = hif.fwd_d_rs;
    @(posedge clk);
    advance(s, fl);
    @(negedge clk);
  endtask

  task automatic issue(int cls, int rs, int rt, int rd, output int stalls);
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(cls, rs, rt, rd, 1'b0);
      if (obs_stall === 1'b1) stalls++;
      else break;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) cycle(C_NONE, 0, 0, 0, 1'b0);
  endtask

  initial begin
    clear_model();
    rst_n = 1'b0;
    set_d(C_CALR, 5, 0, 0);
    hif.flush = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_stall", hif.stall, 2'd0);
      cycle(C_CALR, 5, 0, 5, 1'b0);
    end
    rst_n = 1'b1;
    cycle(C_CALR, 5, 0, 5, 1'b0);
    drain();

    // addu $3,$1,$2 ; addu $4,$3,$3
    cycle(C_CALR, 1, 2, 3, 1'b0);
    issue(C_CALR, 3, 3, 4, cnt);
    chk("addu_stalls", 2'(cnt), FWD ? 2'd0 : 2'd3);
    set_d(C_NONE, 0, 0, 0);
    #1;
    chk("addu_fwd_e_rs", hif.fwd_e_rs, FWD ? 2'd2 : 2'd0);
    chk("addu_fwd_e_rt", hif.fwd_e_rt, FWD ? 2'd2 : 2'd0);
    drain();

    // lw $8,0($9) ; beq $8,$0
    cycle(C_LOAD, 9, 8, 0, 1'b0);
    issue(C_B, 8, 0, 0, cnt);
    chk("lw_beq_stalls", 2'(cnt), FWD ? 2'd2 : 2'd3);
    chk("lw_beq_fwd_d_rs", obs_fwd_d_rs, FWD ? 2'd3 : 2'd0);
    drain();

    // lw $7 ; addu $1,$7,$7
    cycle(C_LOAD, 2, 7, 0, 1'b0);
    issue(C_CALR, 7, 7, 1, cnt);
    chk("lw_addu_stalls", 2'(cnt), FWD ? 2'd1 : 2'd3);
    drain();

    // jal ; jr $31
    cycle(C_JAL, 0, 0, 0, 1'b0);
    issue(C_JR, 31, 0, 0, cnt);
    chk("jal_jr_stalls", 2'(cnt), FWD ? 2'd0 : 2'd3);
    chk("jal_jr_fwd_d_rs", obs_fwd_d_rs, FWD ? 2'd1 : 2'd0);
    drain();

    // lw $5 ; sw $5,0($6)
    cycle(C_LOAD, 1, 5, 0, 1'b0);
    issue(C_STORE, 6, 5, 0, cnt);
    chk("lw_sw_stalls", 2'(cnt), FWD ? 2'd0 : 2'd3);
    cycle(C_NONE, 0, 0, 0, 1'b0);
    set_d(C_NONE, 0, 0, 0);
    #1;
    chk("lw_sw_fwd_m_rt", hif.fwd_m_rt, FWD ? 2'd1 : 2'd0);
    drain();

    // lw $7 ; addu with flush in the stall cycle
    cycle(C_LOAD, 1, 7, 0, 1'b0);
    cycle(C_CALR, 7, 0, 2, 1'b1);
    chk("flush_stall_hi", obs_stall, 2'd1);
    cycle(C_CALR, 7, 0, 2, 1'b0);
    chk("flush_stall_lo", obs_stall, 2'd0);
    drain();

    // reset asserted while stalled
    cycle(C_LOAD, 1, 4, 0, 1'b0);
    set_d(C_CALR, 4, 0, 3);
    #1;
    chk("pre_rst_stall", hif.stall, 2'd1);
    rst_n = 1'b0;
    #1;
    clear_model();
    chk("mid_rst_stall", hif.stall, 2'd0);
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drain();

    for (int i = 0; i < 500; i++) begin
      int rs, rt, rd;
      rs = ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 3));
      rt = int'($urandom_range(0, 3));
      rd = int'($urandom_range(0, 3));
      cycle(int'($urandom_range(0, 8)), rs, rt, rd, $urandom_range(0, 19) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core; it consumes the per-stage instruction-class flags produced by the D-stage decode classifier. It keeps a registered scoreboard of destination register, remaining result latency (Tnew) and source registers for the E, M and W stages. Each cycle it decides whether the D-stage instruction must stall and drives the forwarding-mux selects for the D, E and M stages. It sits between the decode classifier and the datapath mux/enable controls.

## Interface
- No parameters; register index width is fixed at 5, and register 0 is never a hazard.
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- d_b, d_cal_r, d_cal_i, d_load, d_store, d_jr, d_jalr, d_jal  in  1 each  D-stage class flags, one-hot or all-zero
- d_rs, d_rt, d_rd  in  5 each  D-stage register fields
- flush  in  1  kills the instructions in E and M (exception or eret)
- stall  out  1  freeze PC and F/D, and inject a bubble into E
- fwd_d_rs, fwd_d_rt  out  2 each  0 = regfile, 1 = E (PC+8), 2 = M, 3 = W
- fwd_e_rs, fwd_e_rt  out  2 each  0 = pipe register, 2 = M, 3 = W
- fwd_m_rt  out  1  0 = pipe register, 1 = W (store data)

## Operation
- Tuse of rs:
  - 0 for B, JR, JALR.
  - 1 for CAL_R, CAL_I, LOAD, STORE.
  - Unused otherwise.
- Tuse of rt:
  - 0 for B.
  - 1 for CAL_R.
  - 2 for STORE.
  - Unused otherwise.
- Tnew on entry to E: CAL_R and CAL_I = 1; LOAD = 2; JAL and JALR = 0.
- Destination: CAL_R and JALR use rd; CAL_I and LOAD use rt; JAL uses 31. No class means no destination (dst = 0).
- Scoreboard entry per stage: valid, dst, tnew[1:0], rs, rt, rs_used, rt_used.
- Stall:
  - Raised when a used, non-zero D source equals E.dst with E.tnew > Tuse.
  - Or when it equals M.dst with M.tnew > Tuse.
  - Only valid entries are compared.
- Forward select for a D source, first match wins:
  - E (dst match, tnew = 0) -> 1.
  - Else M (tnew = 0) -> 2.
  - Else W -> 3.
  - Else 0.
- E-stage forward selects use E.rs and E.rt against M (tnew = 0) then W. M-stage forward select uses M.rt against W.
- A match with dst = 0 never stalls and never forwards.

## Timing
- stall and all fwd_* outputs are combinational from the current D inputs and the registered entries. They are valid in the same cycle.
- Clock-edge updates:
  - W <= M with tnew = 0.
  - M <= E with tnew = max(E.tnew - 1, 0).
  - E <= D entry, or a bubble (valid = 0) when stall = 1.
- flush = 1 at an edge: E and M load bubbles, and W still loads the old M. flush has priority over stall.
- Reset (rst_n low, asynchronous): all entries are invalid. stall = 0 and all fwd_* = 0 while reset is asserted and on the first cycle after release.
- Reset asserted mid-stall clears the stall immediately.
- A LOAD followed by a dependent CAL_R stalls exactly 1 cycle. A LOAD followed by a dependent B stalls exactly 2 cycles.

## Configuration
- HAZ_FWD_EN defined:
  - Full forwarding as above.
- HAZ_FWD_EN undefined:
  - All fwd_* outputs are tied to 0.
  - stall is raised whenever a used, non-zero D source matches a valid dst in E, M or W, regardless of Tnew.
  - The regfile is not write-through, so a W match also stalls.
  - The Tnew fields may be optimised away.

## Test plan
- Reset: hold rst_n = 0 while driving d_cal_r with d_rs = 5 -> stall = 0 and all fwd_* = 0. E/M/W invalid after release.
- addu $3,$1,$2 then addu $4,$3,$3 -> no stall. fwd_d_* = 0; next cycle fwd_e_rs = fwd_e_rt = 2 (M).
- lw $8,0($9) then beq $8,$0 -> stall high for 2 cycles, then fwd_d_rs = 3 (W) and stall low.
- jal then jr $31 in the delay position -> no stall, fwd_d_rs = 1 (E).
- lw $5 then sw $5,0($6) -> no stall. When sw reaches M, fwd_m_rt = 1.
- lw $7 then addu using $7 with flush asserted in the stall cycle -> E/M bubbled, stall drops next cycle.
- With HAZ_FWD_EN undefined, the sequence of the addu test -> stall for 3 cycles, and all fwd_* = 0.
